ofifo_col: RTL and testbench
============================

// Module: ofifo_col
// PURPOSE
//  Output FIFO directly downstream of the MAC row array. It captures the per-column
//  psums (out_s) using the per-column valid strobes. Columns arrive skewed, so each
//  column has its own FIFO. A row-aligned vector of col psums is presented to the
//  drain side (SFU / output SRAM) only when every column holds at least one entry.
// PARAMETERS
//  col      8   number of MAC columns, one FIFO lane each
//  psum_bw  16  width of one psum, signed two's complement
//  DEPTH    16  entries per lane; power of two, >=2
// PORTS
//  clk      in   1             rising-edge clock
//  reset    in   1             asynchronous, active-low (0 = reset)
//  wr       in   col           per-lane write strobe; wr[i] comes from mac_row valid[i]
//  in       in   psum_bw*col   lane i data is in[psum_bw*(i+1)-1:psum_bw*i]
//  rd       in   1             pop one entry from every lane
//  out      out  psum_bw*col   head entry of every lane, first-word-fall-through
//  o_valid  out  1             every lane non-empty; out holds an aligned row
//  o_full   out  1             at least one lane full
//  o_ready  out  1             ~o_full
//  o_ovf    out  1             sticky: a write was dropped
// BEHAVIOUR
//  - Per lane: wptr/rptr are clog2(DEPTH) bits and wrap modulo DEPTH.
//    cnt is clog2(DEPTH)+1 bits, range 0..DEPTH.
//  - Reset (async, while reset==0): all pointers and counts = 0, o_valid=0, o_full=0,
//    o_ready=1, o_ovf=0. Memory contents are not reset; out is don't-care while !o_valid.
//  - Reset mid-operation: all stored data is discarded at once. No partial rows survive.
//  - pop = rd & o_valid. A pop advances every lane's rptr by 1 on the same edge.
//    rd while !o_valid is ignored: no pointer moves and no error is flagged.
//  - Write lane i is accepted when wr[i] & (cnt_i<DEPTH | pop).
//    Accepted write: mem_i[wptr_i]<=data, wptr_i+1.
//  - Write to a full lane with no pop: dropped, o_ovf<=1 (stays 1 until reset).
//  - cnt_i next = cnt_i + accepted_i - pop. Simultaneous write and pop on a lane
//    leaves cnt_i unchanged; this also applies at cnt_i==DEPTH.
//  - Write to an empty lane: the data is visible on out the cycle after the edge
//    (1-cycle write-to-read latency). There is no bypass in the same cycle.
//  - o_valid = AND over all lanes of (cnt_i!=0).
//  - o_full  = OR over all lanes of (cnt_i==DEPTH).
//  - out is combinational from mem_i[rptr_i]. All status outputs derive from
//    registered counts.
//  - Lanes are fully independent on the write side. The skew between lanes is bounded
//    only by DEPTH.
//  - Upstream contract: mac_row must stall (stop issuing execute) while !o_ready.
//    o_ovf only records a violation of this contract; it does not recover from it.
// CONFIGURATION
//  OFIFO_RELU_EN defined: on an accepted write, a negative psum (MSB=1) is stored as 0.
//    Non-negative values are stored unchanged. Applied per lane, with no added latency.
//  OFIFO_RELU_EN undefined: psums are stored bit-exact.
// TESTING
//  1 reset=0 mid-traffic, then release -> o_valid=0, o_full=0, o_ready=1, o_ovf=0;
//    the next full row reads back alone.
//  2 wr=8'b0000_0001 with 0x0005 for 3 cycles, no other lanes -> o_valid stays 0;
//    lane0 cnt=3.
//  3 skewed fill: lane i written at cycle i with value 0x0100+i -> o_valid rises
//    1 cycle after the lane-7 write; out = {0x0107..0x0100}.
//  4 lane3 written DEPTH times, others empty -> o_full=1, o_ready=0.
//    A 17th write is dropped and sets o_ovf=1; other lanes are unaffected.
//  5 all lanes full, rd=1 plus wr=all-ones with 0xAAAA -> the oldest row pops,
//    0xAAAA is accepted, cnt stays 16, o_ovf stays 0.
//  6 stream 40 rows with rd held high -> data returns in order across pointer wrap.
//    Under OFIFO_RELU_EN, input 0xFFF0 reads back as 0x0000.

Source files
------------

// File: rtl/ofifo_col.sv
// Per-column output FIFO behind the MAC row array; presents a row once every lane holds data.
// Optional build macro OFIFO_RELU_EN: negative psums are clamped to zero on write.
module ofifo_col #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int DEPTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [psum_bw*col-1:0] in,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [psum_bw-1:0]           mem_q [col][DEPTH];
  logic [col-1:0][AW-1:0]       wptr_q, wptr_d;
  logic [col-1:0][AW-1:0]       rptr_q, rptr_d;
  logic [col-1:0][CW-1:0]       cnt_q, cnt_d;
  logic                         ovf_q, ovf_d;
  logic [col-1:0]               acc;
  logic [col-1:0][psum_bw-1:0]  wdata;
  logic                         pop;

  // Status comes only from registered counts.
  always_comb begin
    o_valid = 1'b1;
    o_full  = 1'b0;
    for (int i = 0; i < col; i++) begin
      if (cnt_q[i] == '0)      o_valid = 1'b0;
      if (cnt_q[i] == CNT_FULL) o_full = 1'b1;
    end
    o_ready = ~o_full;
    o_ovf   = ovf_q;
  end

  assign pop = rd & o_valid;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    acc    = '0;
    wdata  = '0;
    for (int i = 0; i < col; i++) begin
      wdata[i] = in[psum_bw*i +: psum_bw];
`ifdef OFIFO_RELU_EN
      if (wdata[i][psum_bw-1]) wdata[i] = '0;
`endif
      // A full lane still takes a write when the same edge pops it.
      acc[i] = wr[i] & ((cnt_q[i] != CNT_FULL) | pop);
      if (wr[i] & ~acc[i]) ovf_d = 1'b1;
      if (acc[i]) wptr_d[i] = wptr_q[i] + AW'(1);
      if (pop)    rptr_d[i] = rptr_q[i] + AW'(1);
      cnt_d[i] = cnt_q[i] + CW'(acc[i]) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage is not reset; clearing the counts is enough to discard it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < col; i++) begin
      if (acc[i]) mem_q[i][wptr_q[i]] <= wdata[i];
    end
  end

  always_comb begin
    out = '0;
    for (int i = 0; i < col; i++) begin
      out[psum_bw*i +: psum_bw] = mem_q[i][rptr_q[i]];
    end
  end

endmodule

// File: tb/tb_ofifo_col.sv
// Scoreboard bench for ofifo_col: per-lane expected queues filled on accepted writes, drained on pops.
module tb_ofifo_col;
  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [COL-1:0]    wr = '0;
  logic [BW*COL-1:0] din = '0;
  logic              rd = 1'b0;
  logic [BW*COL-1:0] dout;
  logic              o_valid, o_full, o_ready, o_ovf;

  int errors = 0;
  int checks = 0;
  logic [BW-1:0] lane_q [COL][$];
  logic          ovf_m = 1'b0;

  always #5 clk = ~clk;

  ofifo_col #(.col(COL), .psum_bw(BW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr(wr), .in(din), .rd(rd), .out(dout),
    .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_ovf(o_ovf)
  );

  function automatic logic [BW-1:0] relu(input logic [BW-1:0] v);
`ifdef OFIFO_RELU_EN
    return v[BW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic bit model_valid();
    for (int i = 0; i < COL; i++) if (lane_q[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [BW*COL-1:0] exp_row();
    logic [BW*COL-1:0] r;
    r = '0;
    for (int i = 0; i < COL; i++) if (lane_q[i].size() != 0) r[BW*i +: BW] = lane_q[i][0];
    return r;
  endfunction

  task automatic set_lane(input int i, input logic [BW-1:0] v);
    din[BW*i +: BW] = v;
  endtask

  // Advance the model by the current inputs, then clock the DUT.
  task automatic tick();
    bit pop;
    pop = rd && model_valid();
    if (pop) for (int i = 0; i < COL; i++) void'(lane_q[i].pop_front());
    for (int i = 0; i < COL; i++) begin
      if (wr[i]) begin
        if (lane_q[i].size() < DEPTH) lane_q[i].push_back(relu(din[BW*i +: BW]));
        else ovf_m = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    wr = '0; rd = 1'b0; din = '0;
    for (int i = 0; i < COL; i++) lane_q[i].delete();
    ovf_m = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_valid); end
    checks++; if (o_full  !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", o_full); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ready); end
    checks++; if (o_ovf   !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", o_ovf); end
    reset = 1'b1;
  endtask

  task automatic test_mid_reset();
    logic [BW*COL-1:0] row;
    apply_reset();
    wr = '1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < COL; i++) set_lane(i, BW'($urandom));
      tick();
    end
    wr = 8'h0F;
    tick();
    wr = '0;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got %b exp 1", o_valid); end
    reset = 1'b0;
    #2;
    for (int i = 0; i < COL; i++) lane_q[i].delete();
    ovf_m = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", o_valid); end
    checks++; if (o_full  !== 1'b0) begin errors++; $display("FAIL midrst_full got %b exp 0", o_full); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", o_ready); end
    checks++; if (o_ovf   !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b exp 0", o_ovf); end
    @(posedge clk); #1 reset = 1'b1;
    wr = '1;
    for (int i = 0; i < COL; i++) begin
      set_lane(i, 16'h0200 + BW'(i));
      row[BW*i +: BW] = 16'h0200 + BW'(i);
    end
    tick();
    wr = '0;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL midrst_row_valid got %b exp 1", o_valid); end
    checks++; if (dout !== row) begin errors++; $display("FAIL midrst_row_data got %h exp %h", dout, row); end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_alone got %b exp 0", o_valid); end
  endtask

  task automatic test_single_lane();
    apply_reset();
    wr = 8'b0000_0001;
    set_lane(0, 16'h0005);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL single_valid k=%0d got %b exp 0", k, o_valid); end
    end
    wr = '0;
    checks++; if (dut.cnt_q[0] !== 5'd3) begin errors++; $display("FAIL single_cnt got %0d exp 3", dut.cnt_q[0]); end
  endtask

  task automatic test_skew();
    logic [BW*COL-1:0] row;
    apply_reset();
    for (int i = 0; i < COL; i++) begin
      wr = '0;
      wr[i] = 1'b1;
      set_lane(i, 16'h0100 + BW'(i));
      row[BW*i +: BW] = 16'h0100 + BW'(i);
      tick();
      checks++;
      if (o_valid !== (i == COL-1)) begin errors++; $display("FAIL skew_valid i=%0d got %b exp %b", i, o_valid, i == COL-1); end
    end
    wr = '0;
    checks++; if (dout !== row) begin errors++; $display("FAIL skew_row got %h exp %h", dout, row); end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL skew_after_pop got %b exp 0", o_valid); end
  endtask

  task automatic test_full_lane();
    apply_reset();
    wr = 8'h08;
    for (int k = 0; k < DEPTH; k++) begin
      set_lane(3, BW'(16'h0300 + k));
      tick();
      checks++; if (o_full !== (k == DEPTH-1)) begin errors++; $display("FAIL lane3_full k=%0d got %b", k, o_full); end
      checks++; if (o_ready !== (k != DEPTH-1)) begin errors++; $display("FAIL lane3_ready k=%0d got %b", k, o_ready); end
    end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL lane3_ovf_early got %b exp 0", o_ovf); end
    set_lane(3, 16'h3333);
    tick();
    wr = '0;
    checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL lane3_ovf got %b exp 1", o_ovf); end
    checks++; if (dut.cnt_q[3] !== 5'd16) begin errors++; $display("FAIL lane3_cnt got %0d exp 16", dut.cnt_q[3]); end
    for (int i = 0; i < COL; i++) begin
      if (i == 3) continue;
      checks++; if (dut.cnt_q[i] !== 5'd0) begin errors++; $display("FAIL lane%0d_untouched got %0d exp 0", i, dut.cnt_q[i]); end
    end
    tick();
    checks++; if (o_ovf !== ovf_m) begin errors++; $display("FAIL lane3_ovf_sticky got %b exp %b", o_ovf, ovf_m); end
  endtask

  task automatic test_full_pop_write();
    apply_reset();
    wr = '1;
    for (int r = 0; r < DEPTH; r++) begin
      for (int i = 0; i < COL; i++) set_lane(i, BW'(r*16 + i));
      tick();
    end
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL allfull_full got %b exp 1", o_full); end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL allfull_valid got %b exp 1", o_valid); end
    rd = 1'b1;
    for (int i = 0; i < COL; i++) set_lane(i, 16'hAAAA);
    checks++; if (dout !== exp_row()) begin errors++; $display("FAIL allfull_head got %h exp %h", dout, exp_row()); end
    tick();
    wr = '0;
    checks++; if (dut.cnt_q[0] !== 5'd16) begin errors++; $display("FAIL allfull_cnt got %0d exp 16", dut.cnt_q[0]); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL allfull_ovf got %b exp 0", o_ovf); end
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL allfull_still_full got %b exp 1", o_full); end
    for (int k = 0; k < DEPTH; k++) begin
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL drain_valid k=%0d got %b exp 1", k, o_valid); end
      checks++; if (dout !== exp_row()) begin errors++; $display("FAIL drain_data k=%0d got %h exp %h", k, dout, exp_row()); end
      tick();
    end
    rd = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", o_valid); end
  endtask

  task automatic test_stream();
    int pops;
    pops = 0;
    apply_reset();
    rd = 1'b1;
    for (int r = 0; r < 40; r++) begin
      wr = '1;
      for (int i = 0; i < COL; i++) set_lane(i, BW'($urandom));
      if (r == 5) set_lane(0, 16'hFFF0);
      if (model_valid()) begin
        pops++;
        checks++; if (dout !== exp_row()) begin errors++; $display("FAIL stream_data r=%0d got %h exp %h", r, dout, exp_row()); end
      end
      tick();
    end
    wr = '0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      if (!model_valid()) break;
      pops++;
      checks++; if (dout !== exp_row()) begin errors++; $display("FAIL stream_tail k=%0d got %h exp %h", k, dout, exp_row()); end
      tick();
    end
    rd = 1'b0;
    checks++; if (pops !== 40) begin errors++; $display("FAIL stream_rows got %0d exp 40", pops); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stream_empty got %b exp 0", o_valid); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL stream_ovf got %b exp 0", o_ovf); end
  endtask

  task automatic test_rd_when_empty();
    apply_reset();
    rd = 1'b1;
    tick();
    tick();
    rd = 1'b0;
    checks++; if (dut.rptr_q[0] !== 4'd0) begin errors++; $display("FAIL idle_rd_ptr got %0d exp 0", dut.rptr_q[0]); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL idle_rd_ovf got %b exp 0", o_ovf); end
  endtask

  initial begin
    test_reset();
    test_mid_reset();
    test_single_lane();
    test_skew();
    test_full_lane();
    test_full_pop_write();
    test_stream();
    test_rd_when_empty();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
